car_enter_exit: RTL and testbench

CAR_ENTER_EXIT -- requirements
Module: car_enter_exit

---
 rtl/car_enter_exit.sv | 135 +++++++++++++
 tb/tb_car_enter_exit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/car_enter_exit.sv
// rtl/car_enter_exit.sv - three-car parking tracker: entry time, stay duration and fee per car (optional COST_SATURATE_EN)
module car_enter_exit (
   input  logic       clk,
   input  logic       reset,
   input  logic       car_enter,
   input  logic       car_exit,
   input  logic [2:0] car_sel,
   input  logic [9:0] timer_count,
   output logic [9:0] car1_enter_time,
   output logic [9:0] car2_enter_time,
   output logic [9:0] car3_enter_time,
   output logic       car1_state,
   output logic       car2_state,
   output logic       car3_state,
   output logic [9:0] car1_count,
   output logic [9:0] car2_count,
   output logic [9:0] car3_count,
   output logic [9:0] car1_cost,
   output logic [9:0] car2_cost,
   output logic [9:0] car3_cost,
   output logic [9:0] currunt_cost
);

`ifdef COST_SATURATE_EN
   localparam logic COST_SAT = 1'b1;
`else
   localparam logic COST_SAT = 1'b0;
`endif

   // Fee is two units per tick; the overflow bit either clamps or is dropped.
   function automatic logic [9:0] fee(input logic [9:0] d);
      logic [10:0] dbl;
      dbl = {1'b0, d} + {1'b0, d};
      fee = dbl[9:0] | {10{COST_SAT & dbl[10]}};
   endfunction

   logic [9:0] enter_time_q [0:2];
   logic [9:0] count_q      [0:2];
   logic [9:0] cost_q       [0:2];
   logic [2:0] state_q;
   logic [9:0] currunt_cost_q;

   logic [2:0] sel_hit;
   logic       enter_req;
   logic       exit_req;
   logic [9:0] dur      [0:2];
   logic [2:0] do_enter;
   logic [2:0] do_exit;
   logic [9:0] exit_fee;

   // Contradictory enter+exit requests cancel each other.
   assign enter_req = car_enter & ~car_exit;
   assign exit_req  = car_exit & ~car_enter;

   // One-hot car select; unused codes select nobody.
   always_comb begin
      sel_hit = 3'b000;
      case (car_sel)
         3'b001:  sel_hit = 3'b001;
         3'b010:  sel_hit = 3'b010;
         3'b011:  sel_hit = 3'b100;
         default: sel_hit = 3'b000;
      endcase
   end

   // Per-car duration (modular, so timer wrap is harmless) and qualified events.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         dur[i]      = timer_count - enter_time_q[i];
         do_enter[i] = sel_hit[i] & enter_req & ~state_q[i];
         do_exit[i]  = sel_hit[i] & exit_req & state_q[i];
      end
   end

   // Fee of the car leaving this cycle (at most one car can leave).
   always_comb begin
      exit_fee = '0;
      for (int i = 0; i < 3; i++) begin
         if (do_exit[i]) begin
            exit_fee = fee(dur[i]);
         end
      end
   end

   // Per-car state: entry captures the time, exit books the fee, parked cars keep counting.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 3; i++) begin
            enter_time_q[i] <= '0;
            count_q[i]      <= '0;
            cost_q[i]       <= '0;
         end
         state_q <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (do_enter[i]) begin
               state_q[i]      <= 1'b1;
               enter_time_q[i] <= timer_count;
               count_q[i]      <= '0;
               cost_q[i]       <= '0;
            end else if (do_exit[i]) begin
               state_q[i] <= 1'b0;
               count_q[i] <= dur[i];
               cost_q[i]  <= fee(dur[i]);
            end else if (state_q[i]) begin
               count_q[i] <= dur[i];
            end
         end
      end
   end

   // Most recent fee charged, across all cars.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         currunt_cost_q <= '0;
      end else if (|do_exit) begin
         currunt_cost_q <= exit_fee;
      end
   end

   assign car1_enter_time = enter_time_q[0];
   assign car2_enter_time = enter_time_q[1];
   assign car3_enter_time = enter_time_q[2];
   assign car1_state      = state_q[0];
   assign car2_state      = state_q[1];
   assign car3_state      = state_q[2];
   assign car1_count      = count_q[0];
   assign car2_count      = count_q[1];
   assign car3_count      = count_q[2];
   assign car1_cost       = cost_q[0];
   assign car2_cost       = cost_q[1];
   assign car3_cost       = cost_q[2];
   assign currunt_cost    = currunt_cost_q;

endmodule

// File: tb/tb_car_enter_exit.sv
// tb/tb_car_enter_exit.sv - self-checking bench for car_enter_exit
module tb_car_enter_exit;

`ifdef COST_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       car_enter;
   logic       car_exit;
   logic [2:0] car_sel;
   logic [9:0] timer_count;
   logic [9:0] car1_enter_time, car2_enter_time, car3_enter_time;
   logic       car1_state, car2_state, car3_state;
   logic [9:0] car1_count, car2_count, car3_count;
   logic [9:0] car1_cost, car2_cost, car3_cost;
   logic [9:0] currunt_cost;

   car_enter_exit dut (
      .clk(clk), .reset(reset), .car_enter(car_enter), .car_exit(car_exit),
      .car_sel(car_sel), .timer_count(timer_count),
      .car1_enter_time(car1_enter_time), .car2_enter_time(car2_enter_time),
      .car3_enter_time(car3_enter_time),
      .car1_state(car1_state), .car2_state(car2_state), .car3_state(car3_state),
      .car1_count(car1_count), .car2_count(car2_count), .car3_count(car3_count),
      .car1_cost(car1_cost), .car2_cost(car2_cost), .car3_cost(car3_cost),
      .currunt_cost(currunt_cost)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: plain integers per car, index 1..3.
   int m_st [1:3];
   int m_et [1:3];
   int m_cnt[1:3];
   int m_cost[1:3];
   int m_cur;

   function automatic int model_fee(input int d);
      int f;
      f = 2 * d;
      if (SAT) return (f > 1023) ? 1023 : f;
      return f % 1024;
   endfunction

   task automatic model_reset();
      for (int c = 1; c <= 3; c++) begin
         m_st[c] = 0; m_et[c] = 0; m_cnt[c] = 0; m_cost[c] = 0;
      end
      m_cur = 0;
   endtask

   task automatic model_step(input int en, input int ex, input int sel, input int t);
      int d;
      for (int c = 1; c <= 3; c++) begin
         d = (t - m_et[c] + 1024) % 1024;
         if (sel == c && en == 1 && ex == 0 && m_st[c] == 0) begin
            m_st[c] = 1; m_et[c] = t; m_cnt[c] = 0; m_cost[c] = 0;
         end else if (sel == c && ex == 1 && en == 0 && m_st[c] == 1) begin
            m_st[c] = 0; m_cnt[c] = d; m_cost[c] = model_fee(d); m_cur = model_fee(d);
         end else if (m_st[c] == 1) begin
            m_cnt[c] = d;
         end
      end
   endtask

   function automatic int dut_st(input int c);
      case (c) 1: return int'(car1_state); 2: return int'(car2_state); default: return int'(car3_state); endcase
   endfunction
   function automatic int dut_et(input int c);
      case (c) 1: return int'(car1_enter_time); 2: return int'(car2_enter_time); default: return int'(car3_enter_time); endcase
   endfunction
   function automatic int dut_cnt(input int c);
      case (c) 1: return int'(car1_count); 2: return int'(car2_count); default: return int'(car3_count); endcase
   endfunction
   function automatic int dut_cost(input int c);
      case (c) 1: return int'(car1_cost); 2: return int'(car2_cost); default: return int'(car3_cost); endcase
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic check_model(input string tag);
      for (int c = 1; c <= 3; c++) begin
         chk($sformatf("%s car%0d_state", tag, c), dut_st(c), m_st[c]);
         chk($sformatf("%s car%0d_enter_time", tag, c), dut_et(c), m_et[c]);
         chk($sformatf("%s car%0d_count", tag, c), dut_cnt(c), m_cnt[c]);
         chk($sformatf("%s car%0d_cost", tag, c), dut_cost(c), m_cost[c]);
      end
      chk($sformatf("%s currunt_cost", tag), int'(currunt_cost), m_cur);
   endtask

   // Drive at posedge+1, let one edge pass, check at posedge+1.
   task automatic step(input int en, input int ex, input int sel, input int t);
      car_enter   = en[0];
      car_exit    = ex[0];
      car_sel     = sel[2:0];
      timer_count = t[9:0];
      @(posedge clk);
      model_step(en, ex, sel, t);
      #1;
   endtask

   typedef struct {
      int en, ex, sel, tmr;
      int exp_st;   // {car3,car2,car1}
      int exp_cur;
      int car;      // car whose detail is checked
      int exp_et, exp_cnt, exp_cost;
   } vec_t;

   vec_t vecs[23];

   initial begin
      int f600;
      int t;
      f600 = SAT ? 1023 : 176;
      vecs = '{
         '{1,0,1,   4, 3'b001,  0, 1,   4,   0,   0},
         '{0,0,0,  10, 3'b001,  0, 1,   4,   6,   0},
         '{1,0,1,  12, 3'b001,  0, 1,   4,   8,   0},
         '{0,1,1,  16, 3'b000, 24, 1,   4,  12,  24},
         '{0,0,0,  30, 3'b000, 24, 1,   4,  12,  24},
         '{1,0,2,  10, 3'b010, 24, 2,  10,   0,   0},
         '{1,0,3,  20, 3'b110, 24, 3,  20,   0,   0},
         '{0,1,2,  40, 3'b100, 60, 2,  10,  30,  60},
         '{0,0,0,  45, 3'b100, 60, 3,  20,  25,   0},
         '{1,0,1,  50, 3'b101, 60, 1,  50,   0,   0},
         '{1,0,1,  55, 3'b101, 60, 1,  50,   5,   0},
         '{0,1,2,  60, 3'b101, 60, 2,  10,  30,  60},
         '{1,1,1,  62, 3'b101, 60, 1,  50,  12,   0},
         '{1,0,7,  64, 3'b101, 60, 1,  50,  14,   0},
         '{0,1,7,  66, 3'b101, 60, 3,  20,  46,   0},
         '{0,1,0,  68, 3'b101, 60, 1,  50,  18,   0},
         '{0,1,1,  70, 3'b100, 40, 1,  50,  20,  40},
         '{0,1,3, 100, 3'b000,160, 3,  20,  80, 160},
         '{1,0,1,   0, 3'b001,160, 1,   0,   0,   0},
         '{0,1,1, 600, 3'b000,f600,1,   0, 600,f600},
         '{1,0,2,1020, 3'b010,f600,2,1020,   0,   0},
         '{0,0,0,   1, 3'b010,f600,2,1020,   5,   0},
         '{0,1,2,   4, 3'b000, 16, 2,1020,   8,  16}
      };

      reset = 1'b1; car_enter = 1'b0; car_exit = 1'b0; car_sel = 3'b000; timer_count = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1;
      chk("reset all_states", int'({car3_state, car2_state, car1_state}), 0);
      chk("reset currunt_cost", int'(currunt_cost), 0);
      check_model("reset");

      // Directed table
      for (int i = 0; i < 23; i++) begin
         step(vecs[i].en, vecs[i].ex, vecs[i].sel, vecs[i].tmr);
         chk($sformatf("vec%0d states", i), int'({car3_state, car2_state, car1_state}), vecs[i].exp_st);
         chk($sformatf("vec%0d currunt_cost", i), int'(currunt_cost), vecs[i].exp_cur);
         chk($sformatf("vec%0d car%0d_enter_time", i, vecs[i].car), dut_et(vecs[i].car), vecs[i].exp_et);
         chk($sformatf("vec%0d car%0d_count", i, vecs[i].car), dut_cnt(vecs[i].car), vecs[i].exp_cnt);
         chk($sformatf("vec%0d car%0d_cost", i, vecs[i].car), dut_cost(vecs[i].car), vecs[i].exp_cost);
         check_model($sformatf("vec%0d", i));
      end

      // Held car_enter yields exactly one entry
      step(1, 0, 1, 200);
      step(1, 0, 1, 210);
      step(1, 0, 1, 220);
      chk("held_enter car1_enter_time", int'(car1_enter_time), 200);
      chk("held_enter car1_count", int'(car1_count), 20);
      step(0, 1, 1, 230);
      chk("held_enter exit cost", int'(car1_cost), 60);

      // Reset mid-stay clears immediately, no fee computed
      step(1, 0, 3, 300);
      step(0, 0, 0, 310);
      #2 reset = 1'b1;
      #1;
      model_reset();
      chk("async_reset car3_state", int'(car3_state), 0);
      chk("async_reset currunt_cost", int'(currunt_cost), 0);
      check_model("async_reset");
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      check_model("post_reset");
      step(0, 1, 3, 320);
      chk("exit_after_reset currunt_cost", int'(currunt_cost), 0);
      check_model("exit_after_reset");

      // Randomized stimulus against the model
      t = 0;
      for (int n = 0; n < 400; n++) begin
         int r, en, ex;
         r  = int'($urandom_range(0, 9));
         en = (r < 4) ? 1 : 0;
         ex = (r >= 3 && r < 7) ? 1 : 0;
         t  = (t + int'($urandom_range(0, 60))) % 1024;
         step(en, ex, int'($urandom_range(0, 7)), t);
         check_model($sformatf("rnd%0d", n));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
